// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch history table predictor.
package bpu_pkg;

  // PC width that the entry struct is sized for.
  localparam int BPU_XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // The tag field is kept full-width and zero-extended so one struct serves
  // any table size; the unused upper bits are constant zero.
  typedef struct packed {
    logic                valid;
    logic [BPU_XLEN-1:0] tag;
    ctr_t                ctr;
    logic [BPU_XLEN-1:0] target;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    ctr:    CTR_RESET,
    target: '0
  };

  // Word index into the table, returned zero-extended.
  function automatic logic [BPU_XLEN-1:0] pcIndex(input logic [BPU_XLEN-1:0] pc,
                                                  input int idxW);
    logic [BPU_XLEN-1:0] mask;
    mask = ~({BPU_XLEN{1'b1}} << idxW);
    return (pc >> 2) & mask;
  endfunction

  // Everything above the index bits.
  function automatic logic [BPU_XLEN-1:0] pcTag(input logic [BPU_XLEN-1:0] pc,
                                                input int idxW);
    return pc >> (idxW + 2);
  endfunction

endpackage

// File: rtl/bpu_bht_if.sv
// Fetch/execute facing bus of the branch predictor.
interface bpu_bht_if #(
  parameter int XLEN = 32
);
  logic            pred_req;
  logic [XLEN-1:0] pred_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;

  logic            mispredict;
  logic [31:0]     perf_br_cnt;
  logic [31:0]     perf_mis_cnt;

  modport master (
    output pred_req, pred_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_valid, pred_taken, pred_target,
    input  mispredict, perf_br_cnt, perf_mis_cnt
  );

  modport slave (
    input  pred_req, pred_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_valid, pred_taken, pred_target,
    output mispredict, perf_br_cnt, perf_mis_cnt
  );
endinterface

// File: rtl/bpu_bht_array.sv
// Entry storage: registered lookup port, combinational read-modify-write port,
// one write port and a synchronous clear of every entry.
module bpu_bht_array
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rdEn,
  input  logic [IDX_W-1:0] i_rdIdx,
  output entry_t           o_rdData,
  input  logic [IDX_W-1:0] i_peekIdx,
  output entry_t           o_peekData,
  input  logic             i_wrEn,
  input  logic [IDX_W-1:0] i_wrIdx,
  input  entry_t           i_wrData
);

  entry_t r_mem [ENTRIES];
  entry_t r_rdData;

  // Clear all entries on reset, otherwise apply the single write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= ENTRY_RESET;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrIdx] <= i_wrData;
    end
  end

  // Lookup port samples the pre-write contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdData <= ENTRY_RESET;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdIdx];
    end
  end

  assign o_rdData   = r_rdData;
  assign o_peekData = r_mem[i_peekIdx];

endmodule

// File: rtl/bpu_bht.sv
// Branch predictor: 2-bit counter table with tagged targets, trained by
// execute and queried by fetch with one cycle of latency.
module bpu_bht
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input logic          clk,
  input logic          rst_n,
  bpu_bht_if.slave     bus
);

  function automatic ctr_t ctrStep(input ctr_t c, input logic taken);
    ctr_t n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = CTR_RESET;
    endcase
    return n;
  endfunction

  logic [IDX_W-1:0] w_reqIdx;
  logic [IDX_W-1:0] w_updIdx;
  entry_t           w_rdData;
  entry_t           w_peekData;
  entry_t           w_wrData;
  logic [XLEN-1:0]  w_updTag;
  logic             w_tagMatch;
  logic             w_hit;
  logic             w_taken;
  logic             w_mis;

  logic             r_predValid;
  logic             r_haveData;
  logic [XLEN-1:0]  r_reqPc;
  logic             r_mispredict;
  logic [31:0]      r_brCnt;
  logic [31:0]      r_misCnt;

  assign w_reqIdx = IDX_W'(pcIndex(bus.pred_pc, IDX_W));
  assign w_updIdx = IDX_W'(pcIndex(bus.upd_pc, IDX_W));
  assign w_updTag = pcTag(bus.upd_pc, IDX_W);

  bpu_bht_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rdEn     (bus.pred_req),
    .i_rdIdx    (w_reqIdx),
    .o_rdData   (w_rdData),
    .i_peekIdx  (w_updIdx),
    .o_peekData (w_peekData),
    .i_wrEn     (bus.upd_valid),
    .i_wrIdx    (w_updIdx),
    .i_wrData   (w_wrData)
  );

  // Build the new entry: step in place on a match or empty slot, else replace.
  always_comb begin
    w_wrData   = w_peekData;
    w_tagMatch = w_peekData.valid && (w_peekData.tag == w_updTag);
    if (!w_peekData.valid || w_tagMatch) begin
      w_wrData.ctr = ctrStep(w_peekData.valid ? w_peekData.ctr : CTR_RESET, bus.upd_taken);
    end else begin
      w_wrData.ctr = bus.upd_taken ? WT : WNT;
    end
    w_wrData.valid = 1'b1;
    w_wrData.tag   = w_updTag;
    if (bus.upd_taken) begin
      w_wrData.target = bus.upd_target;
    end
  end

  // Remember which PC the registered lookup belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_predValid <= 1'b0;
      r_haveData  <= 1'b0;
      r_reqPc     <= '0;
    end else begin
      r_predValid <= bus.pred_req;
      if (bus.pred_req) begin
        r_haveData <= 1'b1;
        r_reqPc    <= bus.pred_pc;
      end
    end
  end

  assign w_hit   = w_rdData.valid && (w_rdData.tag == pcTag(r_reqPc, IDX_W));
  assign w_taken = r_haveData && w_hit && w_rdData.ctr[1];

  assign bus.pred_valid  = r_predValid;
  assign bus.pred_taken  = w_taken;
  assign bus.pred_target = !r_haveData ? '0 :
                           w_taken     ? w_rdData.target : r_reqPc + XLEN'(4);

  assign w_mis = (bus.upd_taken != bus.upd_pred_taken) ||
                 (bus.upd_taken && bus.upd_pred_taken && (bus.upd_target != bus.upd_pred_target));

  // Mispredict pulse and the resolved/mispredicted branch counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mispredict <= 1'b0;
      r_brCnt      <= '0;
      r_misCnt     <= '0;
    end else begin
      r_mispredict <= bus.upd_valid && w_mis;
      if (bus.upd_valid) begin
        r_brCnt <= r_brCnt + 32'd1;
      end
      if (bus.upd_valid && w_mis) begin
        r_misCnt <= r_misCnt + 32'd1;
      end
    end
  end

  assign bus.mispredict   = r_mispredict;
  assign bus.perf_br_cnt  = r_brCnt;
  assign bus.perf_mis_cnt = r_misCnt;

endmodule

// File: tb/tb_bpu_bht.sv
// Bench for bpu_bht: directed vector table plus randomized traffic against
// an array-based reference model of the predictor.
module tb_bpu_bht;

  typedef struct {
    bit          req;
    logic [31:0] pc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    bit          upt;
    logic [31:0] uptgt;
    bit          eValid;
    bit          eTaken;
    logic [31:0] eTarget;
    bit          eMis;
    int          eBr;
    int          eMisCnt;
  } vec_t;

  logic clk;
  logic rst_n;

  bpu_bht_if #(.XLEN(32)) bus();

  bpu_bht #(.ENTRIES(64), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors;
  int nMiscompares;

  // Reference model state: one record per table slot.
  bit          mValid [64];
  logic [31:0] mTag   [64];
  int          mCtr   [64];
  logic [31:0] mTgt   [64];

  bit          expValid;
  bit          expTaken;
  logic [31:0] expTarget;
  bit          expMis;
  logic [31:0] expBr;
  logic [31:0] expMisCnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    nVectors++;
    if (act !== want) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  task automatic modelStep();
    int idx;
    logic [31:0] tag;
    bit hit;
    bit mis;
    int c;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        mValid[i] = 0; mTag[i] = '0; mCtr[i] = 1; mTgt[i] = '0;
      end
      expValid = 0; expTaken = 0; expTarget = '0; expMis = 0;
      expBr = '0; expMisCnt = '0;
      return;
    end
    expValid = bus.pred_req;
    if (bus.pred_req) begin
      idx = int'(bus.pred_pc[7:2]);
      tag = bus.pred_pc >> 8;
      hit = mValid[idx] && (mTag[idx] == tag);
      expTaken  = hit && (mCtr[idx] >= 2);
      expTarget = expTaken ? mTgt[idx] : bus.pred_pc + 32'd4;
    end
    mis = (bus.upd_taken != bus.upd_pred_taken) ||
          (bus.upd_taken && bus.upd_pred_taken && bus.upd_target != bus.upd_pred_target);
    expMis = bus.upd_valid && mis;
    if (bus.upd_valid) begin
      idx = int'(bus.upd_pc[7:2]);
      tag = bus.upd_pc >> 8;
      if (!mValid[idx] || mTag[idx] == tag) begin
        c = mValid[idx] ? mCtr[idx] : 1;
        c = bus.upd_taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        mCtr[idx] = c;
      end else begin
        mCtr[idx] = bus.upd_taken ? 2 : 1;
      end
      mValid[idx] = 1;
      mTag[idx]   = tag;
      if (bus.upd_taken) mTgt[idx] = bus.upd_target;
      expBr = expBr + 32'd1;
      if (mis) expMisCnt = expMisCnt + 32'd1;
    end
  endtask

  task automatic checkOutput();
    cmp("pred_valid",   {31'd0, bus.pred_valid}, {31'd0, expValid});
    cmp("pred_taken",   {31'd0, bus.pred_taken}, {31'd0, expTaken});
    cmp("pred_target",  bus.pred_target,         expTarget);
    cmp("mispredict",   {31'd0, bus.mispredict}, {31'd0, expMis});
    cmp("perf_br_cnt",  bus.perf_br_cnt,         expBr);
    cmp("perf_mis_cnt", bus.perf_mis_cnt,        expMisCnt);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.pred_req        = v.req;
    bus.pred_pc         = v.pc;
    bus.upd_valid       = v.uv;
    bus.upd_pc          = v.upc;
    bus.upd_taken       = v.ut;
    bus.upd_target      = v.utgt;
    bus.upd_pred_taken  = v.upt;
    bus.upd_pred_target = v.uptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  function automatic vec_t mk(bit req, logic [31:0] pc, bit uv, logic [31:0] upc, bit ut,
                              logic [31:0] utgt, bit upt, logic [31:0] uptgt, bit eValid,
                              bit eTaken, logic [31:0] eTarget, bit eMis, int eBr, int eMisCnt);
    vec_t v;
    v.req = req; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.eValid = eValid; v.eTaken = eTaken;
    v.eTarget = eTarget; v.eMis = eMis; v.eBr = eBr; v.eMisCnt = eMisCnt;
    return v;
  endfunction

  function automatic logic [31:0] poolPc();
    logic [31:0] base;
    int k;
    k = int'($urandom_range(0, 7));
    base = 32'h80000000 + 32'(k % 4) * 32'd4 + 32'(k / 4) * 32'h100;
    if ($urandom_range(0, 15) == 0) base = $urandom;
    return base;
  endfunction

  function automatic logic [31:0] poolTgt();
    return 32'h80001000 + 32'($urandom_range(0, 3)) * 32'h40;
  endfunction

  vec_t vecs [$];
  vec_t v;

  localparam logic [31:0] P10 = 32'h80000010;
  localparam logic [31:0] T1  = 32'h80000100;

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    rst_n = 1'b0;

    // Reset held two cycles; the outputs are compared after each edge.
    tick();
    tick();
    rst_n = 1'b1;

    vecs.push_back(mk(1, 32'h80000000, 0, 0, 0, 0, 0, 0,       1, 0, 32'h80000004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 0, 0,               0, 0, 32'h80000004, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 0, 0,               0, 0, 32'h80000004, 1, 2, 2));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 0, 0,               0, 0, 32'h80000004, 1, 3, 3));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 1, T1, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1, P10, 0, 0, 1, T1,               0, 1, T1, 1, 4, 4));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 1, T1, 0, 4, 4));
    vecs.push_back(mk(0, 0, 1, P10, 0, 0, 0, 0,                0, 1, T1, 0, 5, 4));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 0, 32'h80000014, 0, 5, 4));
    vecs.push_back(mk(0, 0, 1, P10, 0, 0, 0, 0,                0, 0, 32'h80000014, 0, 6, 4));
    vecs.push_back(mk(0, 0, 1, P10, 0, 0, 0, 0,                0, 0, 32'h80000014, 0, 7, 4));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 0, 32'h80000014, 0, 7, 4));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 1, T1,              0, 0, 32'h80000014, 0, 8, 4));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 1, T1,              0, 0, 32'h80000014, 0, 9, 4));
    vecs.push_back(mk(0, 0, 1, P10, 1, T1, 1, T1,              0, 0, 32'h80000014, 0, 10, 4));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 1, T1, 0, 10, 4));
    vecs.push_back(mk(0, 0, 1, 32'h80000110, 1, 32'h80000200, 0, 0, 0, 1, T1, 1, 11, 5));
    vecs.push_back(mk(1, P10, 0, 0, 0, 0, 0, 0,                1, 0, 32'h80000014, 0, 11, 5));
    vecs.push_back(mk(1, 32'h80000110, 0, 0, 0, 0, 0, 0,       1, 1, 32'h80000200, 0, 11, 5));
    vecs.push_back(mk(1, 32'h80000020, 1, 32'h80000020, 1, 32'h80000300, 0, 0,
                      1, 0, 32'h80000024, 1, 12, 6));
    vecs.push_back(mk(1, 32'h80000020, 0, 0, 0, 0, 0, 0,       1, 1, 32'h80000300, 0, 12, 6));
    vecs.push_back(mk(0, 0, 1, 32'h80000020, 1, 32'h80000300, 1, 32'h80000400,
                      0, 1, 32'h80000300, 1, 13, 7));
    vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0,       1, 0, 32'h00000000, 0, 13, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 32'h00000000, 0, 13, 7));

    // Directed table: each row is one cycle with its own expected outputs.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      cmp($sformatf("row%0d.valid", i),  {31'd0, bus.pred_valid}, {31'd0, vecs[i].eValid});
      cmp($sformatf("row%0d.taken", i),  {31'd0, bus.pred_taken}, {31'd0, vecs[i].eTaken});
      cmp($sformatf("row%0d.target", i), bus.pred_target,         vecs[i].eTarget);
      cmp($sformatf("row%0d.mis", i),    {31'd0, bus.mispredict}, {31'd0, vecs[i].eMis});
      cmp($sformatf("row%0d.brcnt", i),  bus.perf_br_cnt,         32'(vecs[i].eBr));
      cmp($sformatf("row%0d.miscnt", i), bus.perf_mis_cnt,        32'(vecs[i].eMisCnt));
    end

    // Reset arriving while a request is in flight drops its pred_valid.
    applyStimulus(mk(1, P10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    cmp("inflight.valid_before", {31'd0, bus.pred_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    cmp("inflight.valid_reset", {31'd0, bus.pred_valid}, 32'd0);
    cmp("inflight.target_reset", bus.pred_target, 32'd0);
    rst_n = 1'b1;
    bus.pred_req = 1'b0;
    tick();
    cmp("inflight.dropped", {31'd0, bus.pred_valid}, 32'd0);
    bus.pred_req = 1'b1;
    tick();
    cmp("postreset.taken", {31'd0, bus.pred_taken}, 32'd0);
    cmp("postreset.target", bus.pred_target, 32'h80000014);

    // Random traffic with occasional resets, checked against the model.
    for (int n = 0; n < 2000; n++) begin
      v = mk($urandom_range(0, 1) == 1, poolPc(), $urandom_range(0, 2) != 0, poolPc(),
             $urandom_range(0, 2) != 0, poolTgt(), $urandom_range(0, 1) == 1, poolTgt(),
             0, 0, 0, 0, 0, 0);
      applyStimulus(v);
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
